// File: rtl/dispatch1_2.sv
// Registered 1:2 round-robin dispatcher with a one-entry buffer per channel; words appear one cycle after acceptance.
// in_ready comes from registered state only; `DISPATCH_STRICT_RR_EN forces strict A/B alternation (default skips to a free channel).
module dispatch1_2 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             outA_valid,
    output logic [WIDTH-1:0] outA_data,
    input  logic             outA_ready,
    output logic             outB_valid,
    output logic [WIDTH-1:0] outB_data,
    input  logic             outB_ready,
    output logic             next_sel
);

    logic             bufA_v;
    logic             bufB_v;
    logic [WIDTH-1:0] bufA_d;
    logic [WIDTH-1:0] bufB_d;
    logic             ptr;

    logic             ptr_free;
    logic             target;
    logic             accept;

    always_comb begin
        ptr_free = ptr ? !bufB_v : !bufA_v;
`ifdef DISPATCH_STRICT_RR_EN
        in_ready = ptr_free;
        target   = ptr;
`else
        // If the preferred channel is busy the other one must be free whenever in_ready is high.
        in_ready = !bufA_v || !bufB_v;
        target   = ptr_free ? ptr : ~ptr;
`endif
        accept   = in_valid && in_ready;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bufA_v <= 1'b0;
            bufB_v <= 1'b0;
            bufA_d <= '0;
            bufB_d <= '0;
            ptr    <= 1'b0;
        end else begin
            if (bufA_v && outA_ready) begin
                bufA_v <= 1'b0;
            end
            if (bufB_v && outB_ready) begin
                bufB_v <= 1'b0;
            end
            // The target buffer is always empty at the start of the cycle, so no drain can collide with this load.
            if (accept) begin
                ptr <= ~target;
                if (target) begin
                    bufB_v <= 1'b1;
                    bufB_d <= in_data;
                end else begin
                    bufA_v <= 1'b1;
                    bufA_d <= in_data;
                end
            end
        end
    end

    assign outA_valid = bufA_v;
    assign outA_data  = bufA_d;
    assign outB_valid = bufB_v;
    assign outB_data  = bufB_d;
    assign next_sel   = ptr;

endmodule

// File: tb/tb_dispatch1_2.sv
// Bench for dispatch1_2: directed scenarios plus randomized traffic checked against a queue-based channel model.
module tb_dispatch1_2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic        outA_valid;
    logic [15:0] outA_data;
    logic        outA_ready = 1'b0;
    logic        outB_valid;
    logic [15:0] outB_data;
    logic        outB_ready = 1'b0;
    logic        next_sel;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    dispatch1_2 #(.WIDTH(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .outA_valid (outA_valid),
        .outA_data  (outA_data),
        .outA_ready (outA_ready),
        .outB_valid (outB_valid),
        .outB_data  (outB_data),
        .outB_ready (outB_ready),
        .next_sel   (next_sel)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        in_valid = 1'b0;
        outA_ready = 1'b0;
        outB_ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 16'h5A5A;
        outA_ready = 1'b1;
        outB_ready = 1'b1;
        repeat (2) tick();
        @(negedge clk);
        n_cmp++; if (outA_valid !== 1'b0) begin n_fail++; $display("FAIL reset_outA_valid: got %b expected 0", outA_valid); end
        n_cmp++; if (outB_valid !== 1'b0) begin n_fail++; $display("FAIL reset_outB_valid: got %b expected 0", outB_valid); end
        n_cmp++; if (outA_data !== 16'h0) begin n_fail++; $display("FAIL reset_outA_data: got %h expected 0000", outA_data); end
        n_cmp++; if (outB_data !== 16'h0) begin n_fail++; $display("FAIL reset_outB_data: got %h expected 0000", outB_data); end
        n_cmp++; if (next_sel !== 1'b0) begin n_fail++; $display("FAIL reset_next_sel: got %b expected 0", next_sel); end
        n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
    endtask

    // Words 1..6 back to back: odd words to A, even to B, each visible the cycle after acceptance.
    task automatic test_streaming;
        logic [15:0] w;
        logic        exp_a;
        do_reset();
        outA_ready = 1'b1;
        outB_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            in_valid = (k <= 6);
            in_data  = (k <= 6) ? 16'(k) : 16'h0;
            @(negedge clk);
            if (k <= 6) begin
                n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL stream_in_ready cyc%0d: got %b expected 1", k, in_ready); end
            end
            if (k <= 7) begin
                n_cmp++; if (next_sel !== 1'((k - 1) % 2)) begin n_fail++; $display("FAIL stream_next_sel cyc%0d: got %b expected %0d", k, next_sel, (k - 1) % 2); end
            end
            if (k >= 2 && k <= 7) begin
                w = 16'(k - 1);
                exp_a = w[0];
                n_cmp++; if (outA_valid !== exp_a) begin n_fail++; $display("FAIL stream_outA_valid cyc%0d: got %b expected %b", k, outA_valid, exp_a); end
                n_cmp++; if (outB_valid !== !exp_a) begin n_fail++; $display("FAIL stream_outB_valid cyc%0d: got %b expected %b", k, outB_valid, !exp_a); end
                if (exp_a) begin
                    n_cmp++; if (outA_data !== w) begin n_fail++; $display("FAIL stream_outA_data cyc%0d: got %h expected %h", k, outA_data, w); end
                end else begin
                    n_cmp++; if (outB_data !== w) begin n_fail++; $display("FAIL stream_outB_data cyc%0d: got %h expected %h", k, outB_data, w); end
                end
            end
            tick();
        end
    endtask

    task automatic test_stall_a;
        logic [15:0] words [4];
        logic [15:0] rec_b [$];
        logic [15:0] exp_b [$];
        int          idx;
        int          exp_idx;
        logic        acc;
        words[0] = 16'h0010; words[1] = 16'h0011; words[2] = 16'h0012; words[3] = 16'h0013;
`ifdef DISPATCH_STRICT_RR_EN
        exp_b = '{16'h0011};
        exp_idx = 2;
`else
        exp_b = '{16'h0011, 16'h0012, 16'h0013};
        exp_idx = 4;
`endif
        idx = 0;
        do_reset();
        outA_ready = 1'b0;
        outB_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            in_valid = (idx < 4);
            in_data  = (idx < 4) ? words[idx] : 16'h0;
            @(negedge clk);
            if (outA_valid === 1'b1) begin
                n_cmp++; if (outA_data !== 16'h0010) begin n_fail++; $display("FAIL stall_outA_hold cyc%0d: got %h expected 0010", c, outA_data); end
            end
            if (outB_valid === 1'b1) begin
                rec_b.push_back(outB_data);
                n_cmp++; if (next_sel !== 1'b0) begin n_fail++; $display("FAIL stall_next_sel cyc%0d: got %b expected 0", c, next_sel); end
            end
            acc = in_valid && in_ready;
            tick();
            if (acc) idx++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (idx !== exp_idx) begin n_fail++; $display("FAIL stall_accepted: got %0d expected %0d", idx, exp_idx); end
        n_cmp++; if (rec_b.size() !== exp_b.size()) begin n_fail++; $display("FAIL stall_b_count: got %0d expected %0d", rec_b.size(), exp_b.size()); end
        for (int i = 0; i < exp_b.size() && i < rec_b.size(); i++) begin
            n_cmp++; if (rec_b[i] !== exp_b[i]) begin n_fail++; $display("FAIL stall_b_word%0d: got %h expected %h", i, rec_b[i], exp_b[i]); end
        end
        n_cmp++; if (outA_valid !== 1'b1 || outA_data !== 16'h0010) begin n_fail++; $display("FAIL stall_a_still_held: got %b/%h expected 1/0010", outA_valid, outA_data); end
    endtask

    task automatic test_both_full;
        do_reset();
        outA_ready = 1'b0;
        outB_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 16'h0021; tick();
        in_data = 16'h0022; tick();
        in_data = 16'h0023;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
        n_cmp++; if (outA_data !== 16'h0021 || outB_data !== 16'h0022) begin n_fail++; $display("FAIL full_contents: got %h/%h expected 0021/0022", outA_data, outB_data); end
        tick();
        outB_ready = 1'b1;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready_during_drain: got %b expected 0", in_ready); end
        tick();
        outB_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1 || outB_valid !== 1'b0) begin n_fail++; $display("FAIL full_after_drain: got rdy=%b bv=%b expected rdy=1 bv=0", in_ready, outB_valid); end
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (outB_valid !== 1'b1 || outB_data !== 16'h0023) begin n_fail++; $display("FAIL full_third_word_b: got %b/%h expected 1/0023", outB_valid, outB_data); end
        n_cmp++; if (outA_valid !== 1'b1 || outA_data !== 16'h0021) begin n_fail++; $display("FAIL full_a_held: got %b/%h expected 1/0021", outA_valid, outA_data); end
        n_cmp++; if (next_sel !== 1'b0) begin n_fail++; $display("FAIL full_next_sel: got %b expected 0", next_sel); end
    endtask

    task automatic test_reset_mid;
        do_reset();
        in_valid = 1'b1;
        in_data = 16'h0031; tick();
        in_data = 16'h0032; tick();
        in_valid = 1'b0;
        outA_ready = 1'b1; tick();
        outA_ready = 1'b0;
        in_valid = 1'b1;
        in_data = 16'h0033; tick();
        in_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if (outA_valid !== 1'b1 || outB_valid !== 1'b1 || next_sel !== 1'b1) begin n_fail++; $display("FAIL midrst_setup: got av=%b bv=%b sel=%b expected 1/1/1", outA_valid, outB_valid, next_sel); end
        rst = 1'b1;
        in_valid = 1'b1;
        in_data = 16'hBEEF;
        tick();
        rst = 1'b0;
        in_valid = 1'b0;
        outA_ready = 1'b1;
        outB_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_cmp++; if (outA_valid !== 1'b0 || outB_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_valids cyc%0d: got %b/%b expected 0/0", c, outA_valid, outB_valid); end
            n_cmp++; if (outA_data !== 16'h0 || outB_data !== 16'h0) begin n_fail++; $display("FAIL midrst_data cyc%0d: got %h/%h expected 0000/0000", c, outA_data, outB_data); end
            n_cmp++; if (next_sel !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_sel_rdy cyc%0d: got %b/%b expected 0/1", c, next_sel, in_ready); end
            tick();
        end
    endtask

    task automatic test_simultaneous;
        do_reset();
        in_valid = 1'b1;
        in_data = 16'h0041;
        tick();
        outA_ready = 1'b1;
        in_data = 16'h00AA;
        @(negedge clk);
        n_cmp++; if (in_ready !== 1'b1 || next_sel !== 1'b1 || outA_valid !== 1'b1) begin n_fail++; $display("FAIL simul_setup: got rdy=%b sel=%b av=%b expected 1/1/1", in_ready, next_sel, outA_valid); end
        tick();
        in_valid = 1'b0;
        outA_ready = 1'b0;
        @(negedge clk);
        n_cmp++; if (outA_valid !== 1'b0) begin n_fail++; $display("FAIL simul_outA_valid: got %b expected 0", outA_valid); end
        n_cmp++; if (outB_valid !== 1'b1 || outB_data !== 16'h00AA) begin n_fail++; $display("FAIL simul_outB: got %b/%h expected 1/00aa", outB_valid, outB_data); end
        n_cmp++; if (next_sel !== 1'b0) begin n_fail++; $display("FAIL simul_next_sel: got %b expected 0", next_sel); end
    endtask

    // Model: each channel is a queue of at most one word; the pointer names the preferred channel.
    task automatic test_random;
        logic [15:0] qa [$];
        logic [15:0] qb [$];
        logic        mp;
        logic        exp_rdy;
        logic        pref_free;
        logic        tgt;
        logic        drain_a;
        logic        drain_b;
        do_reset();
        mp = 1'b0;
        for (int c = 0; c < 600; c++) begin
            in_valid   = 1'($urandom_range(0, 1));
            in_data    = 16'($urandom());
            outA_ready = ($urandom_range(0, 3) != 0);
            outB_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            pref_free = mp ? (qb.size() == 0) : (qa.size() == 0);
`ifdef DISPATCH_STRICT_RR_EN
            exp_rdy = pref_free;
            tgt = mp;
`else
            exp_rdy = (qa.size() == 0) || (qb.size() == 0);
            tgt = pref_free ? mp : !mp;
`endif
            n_cmp++; if (in_ready !== exp_rdy) begin n_fail++; $display("FAIL rand_in_ready cyc%0d: got %b expected %b", c, in_ready, exp_rdy); end
            n_cmp++; if (outA_valid !== (qa.size() != 0)) begin n_fail++; $display("FAIL rand_outA_valid cyc%0d: got %b expected %b", c, outA_valid, qa.size() != 0); end
            n_cmp++; if (outB_valid !== (qb.size() != 0)) begin n_fail++; $display("FAIL rand_outB_valid cyc%0d: got %b expected %b", c, outB_valid, qb.size() != 0); end
            n_cmp++; if (next_sel !== mp) begin n_fail++; $display("FAIL rand_next_sel cyc%0d: got %b expected %b", c, next_sel, mp); end
            if (qa.size() != 0) begin
                n_cmp++; if (outA_data !== qa[0]) begin n_fail++; $display("FAIL rand_outA_data cyc%0d: got %h expected %h", c, outA_data, qa[0]); end
            end
            if (qb.size() != 0) begin
                n_cmp++; if (outB_data !== qb[0]) begin n_fail++; $display("FAIL rand_outB_data cyc%0d: got %h expected %h", c, outB_data, qb[0]); end
            end
            drain_a = (qa.size() != 0) && outA_ready;
            drain_b = (qb.size() != 0) && outB_ready;
            if (drain_a) void'(qa.pop_front());
            if (drain_b) void'(qb.pop_front());
            if (in_valid && exp_rdy) begin
                if (tgt) qb.push_back(in_data);
                else     qa.push_back(in_data);
                mp = !tgt;
            end
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_stall_a();
        test_both_full();
        test_reset_mid();
        test_simultaneous();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/dispatch1_2.md
Name: dispatch1_2

Overview:
- Registered 1-to-2 dispatcher. Accepts a word stream on a single valid/ready input and steers each word round-robin to output channel A or B.
- Each channel has a one-entry holding buffer.
- Sequential counterpart to the gate-level 1:2 demux: it produces the select/steering decision and the buffered per-channel outputs that downstream consumers drain independently.

Parameters:
- WIDTH, 16, data word width in bits.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream word present
- in_data  input  WIDTH  upstream word
- in_ready  output  1  dispatcher accepts word this cycle
- outA_valid  output  1  channel A buffer holds a word
- outA_data  output  WIDTH  channel A word
- outA_ready  input  1  channel A consumer takes word
- outB_valid  output  1  channel B buffer holds a word
- outB_data  output  WIDTH  channel B word
- outB_ready  input  1  channel B consumer takes word
- next_sel  output  1  current round-robin pointer (0 = A, 1 = B)

Behaviour:
- State:
  - bufA_v, bufA_d: channel A buffer valid flag and data.
  - bufB_v, bufB_d: channel B buffer valid flag and data.
  - ptr: 1-bit round-robin pointer.
- Reset (rst = 1 at a clk edge): bufA_v = bufB_v = 0, bufA_d = bufB_d = 0, ptr = 0.
  - Resulting outputs: outA_valid = outB_valid = 0, outA_data = outB_data = 0, next_sel = 0, in_ready = 1.
  - Reset dominates all other events in the same cycle.
  - Buffered words are discarded on reset mid-operation.
- Outputs:
  - outX_valid = bufX_v and outX_data = bufX_d, driven directly from registers.
  - next_sel = ptr.
- Accept condition: in_valid && in_ready.
  - in_ready = !bufA_v || !bufB_v, using registered state only.
  - in_ready never depends on in_valid or on outX_ready (no combinational bypass).
- Target selection on accept, evaluated on start-of-cycle state:
  - If buffer[ptr] is free, target = ptr.
  - Otherwise target = the other channel, which is free by the in_ready definition.
- On accept: buffer[target] loads in_data, its valid flag sets, and ptr <= ~target.
  - The next word therefore prefers the opposite channel of the last word written.
- No accept: ptr holds.
- Drain: when outX_valid && outX_ready, bufX_v clears at the edge.
  - A buffer drained in cycle N is free starting cycle N+1. There is no same-cycle drain-and-refill.
  - Per-channel throughput is 1 word per 2 cycles; aggregate throughput is 1 word per cycle when both consumers are always ready.
- Stall: while outX_valid && !outX_ready, outX_data and outX_valid hold stable.
- Both buffers full: in_ready = 0 and in_data is ignored.
- Simultaneous drain of one channel and accept into the other channel in the same cycle: both occur.
- Latency: word accepted at edge N appears on outX at cycle N+1.
- Data is never duplicated, dropped (except on reset), or reordered within a channel.

Optional Feature:
- Macro: DISPATCH_STRICT_RR_EN.
- Defined:
  - Strict alternation; no skipping.
  - in_ready = !buffer[ptr]_v, and target is always ptr.
  - A stalled channel blocks input even if the other channel is free.
- Undefined: skip-to-free-channel behaviour as described in Behaviour (default build).

Test Plan:
- Reset then idle: assert rst 2 cycles.
  -> outA_valid = outB_valid = 0, data = 0, next_sel = 0, in_ready = 1.
- Streaming with both consumers always ready: send 0x0001..0x0006 back-to-back.
  -> A receives 0x0001, 0x0003, 0x0005; B receives 0x0002, 0x0004, 0x0006.
  -> in_ready stays 1 throughout; each word appears 1 cycle after acceptance.
- Stall A with outA_ready = 0, B ready, send 0x0010..0x0013:
  - Default build: A holds 0x0010 stable; B receives 0x0011, 0x0012, 0x0013 (skip); next_sel = 0 after each B write.
  - With DISPATCH_STRICT_RR_EN: 0x0010 goes to A, 0x0011 goes to B, then in_ready = 0 until A drains.
- Both full: outA_ready = outB_ready = 0, send 3 words.
  -> Only 2 accepted; in_ready = 0 with the 3rd word held by upstream.
  -> Raise outB_ready for 1 cycle: B drains, in_ready = 1 the next cycle, and the 3rd word enters B.
- Reset mid-operation: both buffers full, assert rst.
  -> Next cycle both valids = 0, ptr = 0, and no stale word ever appears on outA or outB.
- Simultaneous events: bufA full and draining while bufB is free and in_valid = 1 with 0x00AA in the same cycle.
  -> Next cycle outA_valid = 0, outB_valid = 1, outB_data = 0x00AA, next_sel = 0.
